// File: rtl/periodic_trigger.sv
// ---------------------------------------------------------------------------
// periodic_trigger
//   Programmable interval timer producing single-cycle trigger strobes for the
//   downstream pulse stretcher. It supports one-shot and periodic operation,
//   an optional trigger count (0 = unlimited) and an abort input.
//
// Ports
//   clk           clock, all logic on the rising edge
//   reset         synchronous, active-high reset
//   cfg_valid     load cfg_* into the config registers (IDLE only)
//   cfg_interval  trigger period in cycles (0 behaves as 1)
//   cfg_periodic  1 = periodic, 0 = one-shot
//   cfg_count     periodic trigger count, 0 = unlimited
//   start         begin a sequence (IDLE only)
//   stop          abort a running sequence
//   trig_out      registered single-cycle trigger strobe
//   busy          registered copy of (state == RUN)
//   done          single-cycle pulse when a sequence completes
//   fired_cnt     triggers issued since the last accepted start (saturating)
// ---------------------------------------------------------------------------
module periodic_trigger #(
    parameter int CNT_WIDTH     = 32,
    parameter int EVT_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_valid,
    input  logic [CNT_WIDTH-1:0]     cfg_interval,
    input  logic                     cfg_periodic,
    input  logic [EVT_CNT_WIDTH-1:0] cfg_count,
    input  logic                     start,
    input  logic                     stop,
    output logic                     trig_out,
    output logic                     busy,
    output logic                     done,
    output logic [EVT_CNT_WIDTH-1:0] fired_cnt
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [CNT_WIDTH-1:0]     CNT_ZERO = CNT_WIDTH'(0);
    localparam logic [CNT_WIDTH-1:0]     CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [EVT_CNT_WIDTH-1:0] EVT_ZERO = EVT_CNT_WIDTH'(0);
    localparam logic [EVT_CNT_WIDTH-1:0] EVT_ONE  = EVT_CNT_WIDTH'(1);
    localparam logic [EVT_CNT_WIDTH-1:0] EVT_MAX  = {EVT_CNT_WIDTH{1'b1}};

    logic [0:0]               state_r;
    logic [0:0]               state_nx_s;
    logic [CNT_WIDTH-1:0]     interval_r;
    logic                     periodic_r;
    logic [EVT_CNT_WIDTH-1:0] count_r;
    logic [CNT_WIDTH-1:0]     cnt_r;
    logic [CNT_WIDTH-1:0]     cnt_nx_s;
    logic [EVT_CNT_WIDTH-1:0] fired_r;
    logic [EVT_CNT_WIDTH-1:0] fired_nx_s;
    logic                     trig_r;
    logic                     busy_r;
    logic                     done_r;

    logic                     use_cfg_s;
    logic [CNT_WIDTH-1:0]     sel_interval_s;
    logic [CNT_WIDTH-1:0]     reload_s;
    logic                     start_acc_s;
    logic                     expire_s;
    logic                     fire_s;
    logic                     last_s;

    // Decode of config selection, reload value and the trigger/completion events
    always_comb begin
        use_cfg_s      = (state_r == ST_IDLE) && cfg_valid;
        // A config presented together with start applies to that sequence.
        sel_interval_s = use_cfg_s ? cfg_interval : interval_r;
        if (sel_interval_s == CNT_ZERO) begin
            reload_s = CNT_ZERO;
        end else begin
            reload_s = sel_interval_s - CNT_ONE;
        end
        // stop beats start in IDLE.
        start_acc_s = (state_r == ST_IDLE) && start && !stop;
        expire_s    = (state_r == ST_RUN) && (cnt_r == CNT_ZERO);
        // stop masks a trigger falling due on the same edge.
        fire_s      = expire_s && !stop;
        // fired_r holds the triggers already issued, so the N-th one is seen
        // when fired_r == N-1; count never exceeds EVT_MAX so saturation cannot
        // hide the final trigger.
        if (!periodic_r) begin
            last_s = fire_s;
        end else if (count_r != EVT_ZERO) begin
            last_s = fire_s && (fired_r == (count_r - EVT_ONE));
        end else begin
            last_s = 1'b0;
        end
    end

    // Next-state, down-counter and fired counter logic
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        fired_nx_s = fired_r;
        case (state_r)
            ST_IDLE: begin
                if (start_acc_s) begin
                    state_nx_s = ST_RUN;
                    cnt_nx_s   = reload_s;
                    fired_nx_s = EVT_ZERO;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nx_s = ST_IDLE;
                end else if (expire_s) begin
                    cnt_nx_s = reload_s;
                    if (fired_r == EVT_MAX) begin
                        fired_nx_s = fired_r;
                    end else begin
                        fired_nx_s = fired_r + EVT_ONE;
                    end
                    if (last_s) begin
                        state_nx_s = ST_IDLE;
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end else begin
                    cnt_nx_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Configuration registers, writable only while idle
    always_ff @(posedge clk) begin
        if (reset) begin
            interval_r <= CNT_ONE;
            periodic_r <= 1'b0;
            count_r    <= EVT_ZERO;
        end else if (use_cfg_s) begin
            interval_r <= cfg_interval;
            periodic_r <= cfg_periodic;
            count_r    <= cfg_count;
        end
    end

    // FSM state, interval counter, fired counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            fired_r <= EVT_ZERO;
            trig_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            fired_r <= fired_nx_s;
            trig_r  <= fire_s;
            busy_r  <= (state_r == ST_RUN);
            done_r  <= last_s;
        end
    end

    assign trig_out  = trig_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign fired_cnt = fired_r;

endmodule

// File: tb/tb_periodic_trigger.sv
// ---------------------------------------------------------------------------
// tb_periodic_trigger
//   Directed bench for periodic_trigger. Cycle k below means the value seen
//   just after the k-th rising edge following the edge that sampled start.
//   A second instance with a 2-bit fired counter covers saturation.
// ---------------------------------------------------------------------------
module tb_periodic_trigger;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_valid;
    logic [31:0] cfg_interval;
    logic        cfg_periodic;
    logic [15:0] cfg_count;
    logic        start;
    logic        stop;
    logic        trig_out;
    logic        busy;
    logic        done;
    logic [15:0] fired_cnt;

    logic        n_cfg_valid;
    logic [7:0]  n_cfg_interval;
    logic        n_cfg_periodic;
    logic [1:0]  n_cfg_count;
    logic        n_start;
    logic        n_stop;
    logic        n_trig_out;
    logic        n_busy;
    logic        n_done;
    logic [1:0]  n_fired_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    periodic_trigger #(.CNT_WIDTH(32), .EVT_CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_interval(cfg_interval),
        .cfg_periodic(cfg_periodic), .cfg_count(cfg_count),
        .start(start), .stop(stop),
        .trig_out(trig_out), .busy(busy), .done(done), .fired_cnt(fired_cnt)
    );

    periodic_trigger #(.CNT_WIDTH(8), .EVT_CNT_WIDTH(2)) dut_n (
        .clk(clk), .reset(reset),
        .cfg_valid(n_cfg_valid), .cfg_interval(n_cfg_interval),
        .cfg_periodic(n_cfg_periodic), .cfg_count(n_cfg_count),
        .start(n_start), .stop(n_stop),
        .trig_out(n_trig_out), .busy(n_busy), .done(n_done), .fired_cnt(n_fired_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_cfg(input logic [31:0] iv, input logic per, input logic [15:0] cnt);
        cfg_valid    = 1'b1;
        cfg_interval = iv;
        cfg_periodic = per;
        cfg_count    = cnt;
    endtask

    task automatic check_outs(input string tag, input int k,
                              input logic et, input logic ed, input logic eb);
        chk($sformatf("%s trig k=%0d", tag, k), {31'd0, trig_out}, {31'd0, et});
        chk($sformatf("%s done k=%0d", tag, k), {31'd0, done}, {31'd0, ed});
        chk($sformatf("%s busy k=%0d", tag, k), {31'd0, busy}, {31'd0, eb});
    endtask

    initial begin
        reset = 1'b1; cfg_valid = 1'b0; cfg_interval = 32'd0; cfg_periodic = 1'b0;
        cfg_count = 16'd0; start = 1'b0; stop = 1'b0;
        n_cfg_valid = 1'b0; n_cfg_interval = 8'd0; n_cfg_periodic = 1'b0;
        n_cfg_count = 2'd0; n_start = 1'b0; n_stop = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check_outs("RST", 0, 1'b0, 1'b0, 1'b0);
        chk("RST fired", {16'd0, fired_cnt}, 32'd0);
        chk("RST n_fired", {30'd0, n_fired_cnt}, 32'd0);

        // Reset config: interval 1, one-shot -> trigger and done on k=1
        start = 1'b1; tick(); start = 1'b0;
        tick(); check_outs("T0", 1, 1'b1, 1'b1, 1'b1);
        chk("T0 fired", {16'd0, fired_cnt}, 32'd1);
        tick(); check_outs("T0", 2, 1'b0, 1'b0, 1'b0);

        // T1 one-shot, I=5
        load_cfg(32'd5, 1'b0, 16'd0); tick(); cfg_valid = 1'b0;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check_outs("T1", k, (k == 5), (k == 5), (k <= 5));
        end
        chk("T1 fired", {16'd0, fired_cnt}, 32'd1);

        // T2 periodic I=3 count=4, cfg and start on the same edge
        load_cfg(32'd3, 1'b1, 16'd4); start = 1'b1; tick();
        cfg_valid = 1'b0; start = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            check_outs("T2", k, ((k % 3) == 0) && (k <= 12), (k == 12), (k <= 12));
            if (k == 7) chk("T2 fired mid", {16'd0, fired_cnt}, 32'd2);
        end
        chk("T2 fired", {16'd0, fired_cnt}, 32'd4);

        // T3 stop on the edge where the second trigger is due
        load_cfg(32'd4, 1'b1, 16'd0); start = 1'b1; tick();
        cfg_valid = 1'b0; start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            stop = (k == 8);
            tick();
            stop = 1'b0;
            check_outs("T3", k, (k == 4), 1'b0, (k <= 8));
        end
        chk("T3 fired", {16'd0, fired_cnt}, 32'd1);

        // T4 interval 0 behaves as 1
        load_cfg(32'd0, 1'b1, 16'd3); start = 1'b1; tick();
        cfg_valid = 1'b0; start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_outs("T4", k, (k <= 3), (k == 3), (k <= 3));
        end
        chk("T4 fired", {16'd0, fired_cnt}, 32'd3);

        // T5 cfg_valid and start in RUN are ignored
        load_cfg(32'd4, 1'b1, 16'd0); start = 1'b1; tick();
        cfg_valid = 1'b0; start = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            if (k == 6) begin
                load_cfg(32'd9, 1'b0, 16'd1);
                start = 1'b1;
            end
            stop = (k == 13);
            tick();
            cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
            check_outs("T5", k, ((k % 4) == 0), 1'b0, 1'b1);
            if (k == 12) chk("T5 fired", {16'd0, fired_cnt}, 32'd3);
        end
        tick(); check_outs("T5", 14, 1'b0, 1'b0, 1'b0);
        // start+stop in IDLE: stays idle, fired_cnt kept
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_outs("T5b", k, 1'b0, 1'b0, 1'b0);
        end
        chk("T5b fired", {16'd0, fired_cnt}, 32'd3);

        // T6 reset mid-RUN on an edge where a trigger is due
        load_cfg(32'd2, 1'b1, 16'd0); start = 1'b1; tick();
        cfg_valid = 1'b0; start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_outs("T6", k, (k == 2), 1'b0, 1'b1);
        end
        reset = 1'b1; tick(); reset = 1'b0;
        check_outs("T6 rst", 4, 1'b0, 1'b0, 1'b0);
        chk("T6 rst fired", {16'd0, fired_cnt}, 32'd0);
        // Config back to interval 1 one-shot
        start = 1'b1; tick(); start = 1'b0;
        tick(); check_outs("T6 cfg", 1, 1'b1, 1'b1, 1'b1);

        // T6 saturation on the 2-bit instance, I=1 unlimited
        n_cfg_valid = 1'b1; n_cfg_interval = 8'd1; n_cfg_periodic = 1'b1;
        n_cfg_count = 2'd0; n_start = 1'b1; tick();
        n_cfg_valid = 1'b0; n_start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("SAT fired k=%0d", k), {30'd0, n_fired_cnt}, (k < 3) ? k : 3);
            chk($sformatf("SAT trig k=%0d", k), {31'd0, n_trig_out}, 32'd1);
            chk($sformatf("SAT done k=%0d", k), {31'd0, n_done}, 32'd0);
        end
        n_stop = 1'b1; tick(); n_stop = 1'b0;
        chk("SAT stop trig", {31'd0, n_trig_out}, 32'd0);
        tick();
        chk("SAT stop busy", {31'd0, n_busy}, 32'd0);
        chk("SAT hold fired", {30'd0, n_fired_cnt}, 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
